// File: rtl/byte_data_memory.sv
// byte_data_memory
//   Byte-addressable data memory built from 32-bit words. It supports
//   byte, half-word and word loads and stores, with sign or zero extension
//   on loads and a configurable read latency. After reset, the memory zeroes
//   itself one word per cycle before it accepts any requests.
//
// Parameters
//   MEM_DEPTH     number of 32-bit words
//   READ_LATENCY  cycles from load acceptance to response (1..4)
//
// Ports
//   clk           sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   req_valid     request present
//   req_ready     request accepted on this cycle's rising edge (IDLE only)
//   req_write     1 = store, 0 = load
//   req_addr      byte address
//   req_size      00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned  load zero-extends when 1, sign-extends when 0
//   req_wdata     store data, right-aligned
//   resp_valid    one-cycle response pulse
//   resp_rdata    extended load result; 0 for stores, errors and idle cycles
//   resp_error    request rejected; only meaningful with resp_valid
//   init_done     memory clear finished
module byte_data_memory #(
  parameter int MEM_DEPTH    = 16384,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        init_done
);

  localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // READ_WAIT runs READ_LATENCY-1 cycles; the counter counts down to 0.
  // This value is unused when READ_LATENCY is 1.
  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 2);

  typedef enum logic [1:0] {CLEAR, IDLE, READ_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_idx_reg, clr_idx_next;
  logic [1:0]        wait_reg, wait_next;
  logic              resp_valid_reg, resp_valid_next;
  // Attributes of the response in flight, captured at acceptance.
  logic              rsp_load_reg, rsp_load_next;
  logic              rsp_err_reg, rsp_err_next;
  logic              rsp_unsigned_reg, rsp_unsigned_next;
  logic [1:0]        rsp_size_reg, rsp_size_next;
  logic [1:0]        rsp_lane_reg, rsp_lane_next;

  logic        accept;
  logic        req_err;
  logic [31:0] word_idx;
  logic [1:0]  lane;

  assign req_ready = (state_reg == IDLE);
  assign init_done = (state_reg != CLEAR);
  assign accept    = req_valid && req_ready;
  assign word_idx  = {2'b00, req_addr[31:2]};
  assign lane      = req_addr[1:0];

  // Bounds are checked on the full word index. The RAM is then addressed
  // with truncated bits, so an out-of-range request must never reach it.
  assign req_err = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || (word_idx >= 32'(MEM_DEPTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= CLEAR;
      clr_idx_reg      <= '0;
      wait_reg         <= '0;
      resp_valid_reg   <= 1'b0;
      rsp_load_reg     <= 1'b0;
      rsp_err_reg      <= 1'b0;
      rsp_unsigned_reg <= 1'b0;
      rsp_size_reg     <= '0;
      rsp_lane_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      clr_idx_reg      <= clr_idx_next;
      wait_reg         <= wait_next;
      resp_valid_reg   <= resp_valid_next;
      rsp_load_reg     <= rsp_load_next;
      rsp_err_reg      <= rsp_err_next;
      rsp_unsigned_reg <= rsp_unsigned_next;
      rsp_size_reg     <= rsp_size_next;
      rsp_lane_reg     <= rsp_lane_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    clr_idx_next      = clr_idx_reg;
    wait_next         = wait_reg;
    resp_valid_next   = 1'b0;
    rsp_load_next     = rsp_load_reg;
    rsp_err_next      = rsp_err_reg;
    rsp_unsigned_next = rsp_unsigned_reg;
    rsp_size_next     = rsp_size_reg;
    rsp_lane_next     = rsp_lane_reg;
    case (state_reg)
      CLEAR: begin
        clr_idx_next = clr_idx_reg + 1'b1;
        if (clr_idx_reg == ADDR_W'(MEM_DEPTH - 1)) begin
          clr_idx_next = '0;
          state_next   = IDLE;
        end
      end
      IDLE: begin
        if (accept) begin
          rsp_load_next     = !req_write;
          rsp_err_next      = req_err;
          rsp_unsigned_next = req_unsigned;
          rsp_size_next     = req_size;
          rsp_lane_next     = lane;
          // Stores, and loads at latency 1, answer in the next cycle.
          if (req_write || READ_LATENCY == 1) begin
            resp_valid_next = 1'b1;
          end else begin
            state_next = READ_WAIT;
            wait_next  = WAIT_INIT;
          end
        end
      end
      READ_WAIT: begin
        if (wait_reg == 2'd0) begin
          state_next      = IDLE;
          resp_valid_next = 1'b1;
        end else begin
          wait_next = wait_reg - 1'b1;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // RAM write/read control. The clear sweep owns the write port while in
  // CLEAR. Stores replicate the data across lanes so that each lane only
  // needs its own byte enable.
  logic [3:0]        byte_en;
  logic [31:0]       wr_word;
  logic [ADDR_W-1:0] mem_idx;
  logic              mem_rd;
  logic [31:0]       rd_word;

  always_comb begin
    byte_en = 4'b0000;
    wr_word = '0;
    mem_idx = req_addr[2 +: ADDR_W];
    if (state_reg == CLEAR) begin
      byte_en = 4'b1111;
      mem_idx = clr_idx_reg;
    end else if (accept && req_write && !req_err) begin
      case (req_size)
        2'b00: begin
          byte_en = 4'b0001 << lane;
          wr_word = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          byte_en = lane[1] ? 4'b1100 : 4'b0011;
          wr_word = {2{req_wdata[15:0]}};
        end
        default: begin
          byte_en = 4'b1111;
          wr_word = req_wdata;
        end
      endcase
    end
  end

  assign mem_rd = accept && !req_write && !req_err;

  // One byte-wide RAM per lane, each with a registered read. The captured
  // word holds steady through READ_WAIT because nothing else is accepted.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [MEM_DEPTH];
    logic [7:0] rd_q;
    always_ff @(posedge clk) begin
      if (byte_en[gi]) lane_mem[mem_idx] <= wr_word[8*gi +: 8];
      if (mem_rd)      rd_q <= lane_mem[mem_idx];
    end
    assign rd_word[8*gi +: 8] = rd_q;
  end

  logic [31:0] shifted;
  logic [31:0] load_ext;

  always_comb begin
    shifted  = rd_word >> {rsp_lane_reg, 3'b000};
    load_ext = rd_word;
    case (rsp_size_reg)
      2'b00: load_ext = rsp_unsigned_reg ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_ext = rsp_unsigned_reg ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = rd_word;
    endcase
  end

  assign resp_valid = resp_valid_reg;
  assign resp_error = resp_valid_reg && rsp_err_reg;
  assign resp_rdata = (resp_valid_reg && rsp_load_reg && !rsp_err_reg) ? load_ext : '0;

endmodule
